// File: rtl/perceptron_pkg.sv
// Shared perceptron predictor constants and types used by the table, predictor and trainer.
// Optional statistics counters in the trainer are enabled with TRAIN_STATS_EN.
package perceptron_pkg;

    localparam int unsigned PERC_NUM_PERCEPTRONS = 128;
    localparam int unsigned PERC_HISTORY_LENGTH  = 32;
    localparam int unsigned PERC_WEIGHT_WIDTH    = 8;

    typedef logic signed [PERC_WEIGHT_WIDTH-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        UPDATE,
        WRITE
    } trainer_state_e;

    // Training threshold floor(1.93*h + 14), kept in integer arithmetic.
    function automatic int unsigned theta(input int unsigned h);
        return (193 * h) / 100 + 14;
    endfunction

endpackage

// File: rtl/perceptron_weight_sat.sv
// Saturating increment/decrement of one signed perceptron weight.
// The result clamps at the most positive/negative representable value instead of wrapping.
module perceptron_weight_sat
    import perceptron_pkg::*;
#(
    parameter int unsigned WIDTH = PERC_WEIGHT_WIDTH
) (
    input  logic signed [WIDTH-1:0] weight,
    input  logic                    inc,
    output logic signed [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    always_comb begin
        result = weight;
        if (inc) begin
            if (weight != W_MAX) begin
                result = weight + W_ONE;
            end
        end else begin
            if (weight != W_MIN) begin
                result = weight - W_ONE;
            end
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: reads an indexed weight vector, applies the saturating perceptron rule and
// writes it back. Defining TRAIN_STATS_EN adds trained/skipped request counters.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned NUM_PERCEPTRONS = PERC_NUM_PERCEPTRONS,
    parameter int unsigned HISTORY_LENGTH  = PERC_HISTORY_LENGTH,
    parameter int unsigned WEIGHT_WIDTH    = PERC_WEIGHT_WIDTH,
    parameter int unsigned ADDR_WIDTH      = $clog2(NUM_PERCEPTRONS),
    parameter int unsigned SUM_WIDTH       = WEIGHT_WIDTH + $clog2(HISTORY_LENGTH + 2),
    parameter int unsigned THETA           = theta(HISTORY_LENGTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,

    input  logic                                   train_valid,
    output logic                                   train_ready,
    input  logic [ADDR_WIDTH-1:0]                  train_addr,
    input  logic [HISTORY_LENGTH-1:0]              train_history,
    input  logic signed [SUM_WIDTH-1:0]            train_y,
    input  logic                                   train_taken,

    output logic [ADDR_WIDTH-1:0]                  tbl_rd_addr,
    input  logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0] tbl_rd_weights,
    output logic                                   tbl_write_en,
    output logic [ADDR_WIDTH-1:0]                  tbl_write_addr,
    output logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0] tbl_new_weights,

`ifdef TRAIN_STATS_EN
    output logic [31:0]                            stat_trained,
    output logic [31:0]                            stat_skipped,
`endif
    output logic                                   busy
);

    localparam int unsigned NUM_WEIGHTS = HISTORY_LENGTH + 1;
    localparam logic [SUM_WIDTH-1:0] THETA_W = SUM_WIDTH'(THETA);
    localparam logic [SUM_WIDTH-1:0] SUM_ONE = SUM_WIDTH'(1);

    trainer_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [HISTORY_LENGTH-1:0]  hist_q, hist_d;
    logic                       taken_q, taken_d;

    logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0] rd_q;
    logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0] upd_q;
    logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0] upd;

    logic                 accept;
    logic                 need;
    logic                 y_neg;
    logic [SUM_WIDTH-1:0] y_mag;

    // Prediction was "taken" when y >= 0, so a sign bit equal to the outcome is a mispredict.
    always_comb begin
        y_neg = train_y[SUM_WIDTH-1];
        y_mag = y_neg ? (~train_y + SUM_ONE) : train_y;
        need  = (y_neg == train_taken) || (y_mag <= THETA_W);
    end

    assign train_ready = (state_q == IDLE) && rst_n;
    assign accept      = train_valid && train_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hist_d  = hist_q;
        taken_d = taken_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = train_addr;
                    hist_d  = train_history;
                    taken_d = train_taken;
                    if (need) begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH:   state_d = UPDATE;
            UPDATE:  state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            hist_q  <= '0;
            taken_q <= 1'b0;
            rd_q    <= '0;
            upd_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hist_q  <= hist_d;
            taken_q <= taken_d;
            if (state_q == FETCH) begin
                rd_q <= tbl_rd_weights;
            end
            if (state_q == UPDATE) begin
                upd_q <= upd;
            end
        end
    end

    // Bias moves toward the outcome; weight i moves toward agreement of history bit i-1 and outcome.
    for (genvar i = 0; i < NUM_WEIGHTS; i++) begin : g_sat
        logic inc;
        if (i == 0) begin : g_bias
            assign inc = taken_q;
        end else begin : g_hist
            assign inc = ~(hist_q[i-1] ^ taken_q);
        end
        perceptron_weight_sat #(
            .WIDTH (WEIGHT_WIDTH)
        ) u_sat (
            .weight (rd_q[i]),
            .inc    (inc),
            .result (upd[i])
        );
    end

    assign busy            = (state_q != IDLE);
    assign tbl_rd_addr     = addr_q;
    assign tbl_write_en    = (state_q == WRITE);
    assign tbl_write_addr  = addr_q;
    assign tbl_new_weights = upd_q;

`ifdef TRAIN_STATS_EN
    logic [31:0] trained_q, skipped_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trained_q <= '0;
            skipped_q <= '0;
        end else if (accept) begin
            if (need) begin
                if (trained_q != '1) trained_q <= trained_q + 32'd1;
            end else begin
                if (skipped_q != '1) skipped_q <= skipped_q + 32'd1;
            end
        end
    end

    assign stat_trained = trained_q;
    assign stat_skipped = skipped_q;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: directed vector table, hand-written corner sequences
// and randomized requests checked against an arithmetic reference model.
module tb_perceptron_trainer;

    localparam int H  = 32;
    localparam int W  = 8;
    localparam int NW = H + 1;
    localparam int AW = 7;
    localparam int SW = 14;
    localparam int VW = NW * W;
    localparam int THETA = 75;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 train_valid = 1'b0;
    logic                 train_ready;
    logic [AW-1:0]        train_addr = '0;
    logic [H-1:0]         train_history = '0;
    logic signed [SW-1:0] train_y = '0;
    logic                 train_taken = 1'b0;
    logic [AW-1:0]        tbl_rd_addr;
    logic [H:0][W-1:0]    tbl_rd_weights;
    logic                 tbl_write_en;
    logic [AW-1:0]        tbl_write_addr;
    logic [H:0][W-1:0]    tbl_new_weights;
    logic                 busy;
`ifdef TRAIN_STATS_EN
    logic [31:0]          stat_trained;
    logic [31:0]          stat_skipped;
`endif

    perceptron_trainer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .train_valid     (train_valid),
        .train_ready     (train_ready),
        .train_addr      (train_addr),
        .train_history   (train_history),
        .train_y         (train_y),
        .train_taken     (train_taken),
        .tbl_rd_addr     (tbl_rd_addr),
        .tbl_rd_weights  (tbl_rd_weights),
        .tbl_write_en    (tbl_write_en),
        .tbl_write_addr  (tbl_write_addr),
        .tbl_new_weights (tbl_new_weights),
`ifdef TRAIN_STATS_EN
        .stat_trained    (stat_trained),
        .stat_skipped    (stat_skipped),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Weight table seen by the DUT, and the model's view of what it should contain.
    logic [H:0][W-1:0] mem     [128];
    logic [H:0][W-1:0] ref_mem [128];
    assign tbl_rd_weights = mem[tbl_rd_addr];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_trained = 0;
    int exp_skipped = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act,
                             input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit model_need(input int y, input bit taken);
        bit pred_taken;
        int mag;
        pred_taken = (y >= 0);
        mag = (y < 0) ? -y : y;
        return (pred_taken != taken) || (mag <= THETA);
    endfunction

    function automatic logic [VW-1:0] model_update(input logic [VW-1:0] cur,
                                                   input logic [H-1:0] hist, input bit taken);
        logic [VW-1:0] res;
        int w, d;
        for (int i = 0; i < NW; i++) begin
            w = int'($signed(cur[i*W +: W]));
            d = taken ? 1 : -1;
            if (i > 0 && !hist[i-1]) d = -d;
            w = w + d;
            if (w > 127) w = 127;
            if (w < -128) w = -128;
            res[i*W +: W] = W'(w);
        end
        return res;
    endfunction

    function automatic int lane(input logic [VW-1:0] v, input int i);
        return int'($signed(v[i*W +: W]));
    endfunction

    function automatic logic [VW-1:0] fill(input int val);
        logic [VW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*W +: W] = W'(val);
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int k = 0;
        while (!train_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_ready_wait"}, 64'(train_ready), 64'd1);
    endtask

    task automatic present(input int addr, input logic [H-1:0] hist, input int y, input bit taken);
        train_addr    = AW'(addr);
        train_history = hist;
        train_y       = SW'(y);
        train_taken   = taken;
        train_valid   = 1'b1;
    endtask

    // Issue one request and follow it to completion, checking cycle-accurate behaviour.
    task automatic run_req(input string name, input int addr, input logic [H-1:0] hist,
                           input int y, input bit taken, input bit exp_need,
                           input bit chk_lanes, input int w0, input int w1, input int w32);
        logic [VW-1:0] expw;
        bit            seen;
        wait_ready(name);
        present(addr, hist, y, taken);
        @(negedge clk);
        train_valid = 1'b0;
        if (exp_need) begin
            exp_trained++;
            expw = model_update(ref_mem[addr], hist, taken);
            ref_mem[addr] = expw;
            check({name, "_busy"}, 64'(busy), 64'd1);
            seen = tbl_write_en;
            @(negedge clk);
            seen |= tbl_write_en;
            check({name, "_no_early_write"}, 64'(seen), 64'd0);
            @(negedge clk);
            check({name, "_write_en"}, 64'(tbl_write_en), 64'd1);
            check({name, "_write_addr"}, 64'(tbl_write_addr), 64'(addr));
            check_vec({name, "_weights"}, tbl_new_weights, expw);
            if (chk_lanes) begin
                check({name, "_w0"}, 64'(lane(tbl_new_weights, 0)), 64'(w0));
                check({name, "_w1"}, 64'(lane(tbl_new_weights, 1)), 64'(w1));
                check({name, "_w32"}, 64'(lane(tbl_new_weights, 32)), 64'(w32));
            end
            if (tbl_write_en) mem[tbl_write_addr] = tbl_new_weights;
            @(negedge clk);
            check({name, "_ready_en_busy_after"}, {61'd0, train_ready, tbl_write_en, busy},
                  64'b100);
        end else begin
            exp_skipped++;
            check({name, "_skip_ready_en_busy"}, {61'd0, train_ready, tbl_write_en, busy},
                  64'b100);
            seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                seen |= tbl_write_en;
            end
            check({name, "_skip_no_write"}, 64'(seen), 64'd0);
        end
    endtask

    typedef struct {
        string         name;
        int            addr;
        logic [H-1:0]  hist;
        int            y;
        bit            taken;
        bit            do_pre;
        int            pre;
        bit            exp_need;
        int            w0;
        int            w1;
        int            w32;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] exp_a, exp_b;
        logic [H-1:0]  h_a, h_b;
        bit            seen;
        int            addr, y;
        bit            taken;
        logic [H-1:0]  hist;

        for (int i = 0; i < 128; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        //         name        addr hist          y      tk pre val   need w0    w1    w32
        vecs[0] = '{"basic",    5, 32'hFFFF_0000,   0,   1, 1,    0,  1,    1,   -1,    1};
        vecs[1] = '{"correct",  6, 32'h1234_5678, 200,   1, 0,    0,  0,    0,    0,    0};
        vecs[2] = '{"sat_hi",   7, 32'hFFFF_FFFF,   0,   1, 1,  127,  1,  127,  127,  127};
        vecs[3] = '{"sat_lo",   8, 32'hFFFF_FFFF,   0,   0, 1, -128,  1, -128, -128, -128};
        vecs[4] = '{"y_p75",    9, 32'h0000_0000,  75,   1, 1,   10,  1,   11,    9,    9};
        vecs[5] = '{"y_p76",    9, 32'h0000_0000,  76,   1, 0,    0,  0,    0,    0,    0};
        vecs[6] = '{"y_m1",    10, 32'hAAAA_AAAA,  -1,   1, 1,   -5,  1,   -4,   -6,   -4};
        vecs[7] = '{"y_m76",   10, 32'hAAAA_AAAA, -76,   0, 0,    0,  0,    0,    0,    0};
        vecs[8] = '{"y_m75",   11, 32'h0000_0000, -75,   0, 1,  127,  1,  126,  127,  127};
        vecs[9] = '{"y_min",   11, 32'h0000_0000, -8192, 0, 0,    0,  0,    0,    0,    0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(train_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_write_en", 64'(tbl_write_en), 64'd0);
        check("reset_rd_addr", 64'(tbl_rd_addr), 64'd0);
        check("reset_write_addr", 64'(tbl_write_addr), 64'd0);
        check_vec("reset_new_weights", tbl_new_weights, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 64'(train_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_pre) begin
                mem[vecs[i].addr]     = fill(vecs[i].pre);
                ref_mem[vecs[i].addr] = fill(vecs[i].pre);
            end
            run_req(vecs[i].name, vecs[i].addr, vecs[i].hist, vecs[i].y, vecs[i].taken,
                    vecs[i].exp_need, vecs[i].exp_need, vecs[i].w0, vecs[i].w1, vecs[i].w32);
        end

        // Back-to-back requests to addrs 3 and 4: second accepted four cycles after the first.
        h_a = $urandom;
        h_b = $urandom;
        wait_ready("b2b");
        present(3, h_a, 0, 1);
        @(negedge clk);
        exp_a = model_update(ref_mem[3], h_a, 1'b1);
        ref_mem[3] = exp_a;
        exp_trained++;
        present(4, h_b, 0, 1);
        check("b2b_ready_n1", 64'(train_ready), 64'd0);
        @(negedge clk);
        check("b2b_ready_n2", 64'(train_ready), 64'd0);
        @(negedge clk);
        check("b2b_write_en_n3", 64'(tbl_write_en), 64'd1);
        check("b2b_write_addr_n3", 64'(tbl_write_addr), 64'd3);
        check_vec("b2b_weights_n3", tbl_new_weights, exp_a);
        check("b2b_ready_n3", 64'(train_ready), 64'd0);
        if (tbl_write_en) mem[tbl_write_addr] = tbl_new_weights;
        @(negedge clk);
        check("b2b_ready_n4", 64'(train_ready), 64'd1);
        @(negedge clk);
        train_valid = 1'b0;
        exp_b = model_update(ref_mem[4], h_b, 1'b1);
        ref_mem[4] = exp_b;
        exp_trained++;
        check("b2b_busy_n5", 64'(busy), 64'd1);
        seen = tbl_write_en;
        @(negedge clk);
        seen |= tbl_write_en;
        check("b2b_no_write_n5_n6", 64'(seen), 64'd0);
        @(negedge clk);
        check("b2b_write_en_n7", 64'(tbl_write_en), 64'd1);
        check("b2b_write_addr_n7", 64'(tbl_write_addr), 64'd4);
        check_vec("b2b_weights_n7", tbl_new_weights, exp_b);
        if (tbl_write_en) mem[tbl_write_addr] = tbl_new_weights;
        @(negedge clk);
        check("b2b_ready_n8", 64'(train_ready), 64'd1);

        // Reset while in UPDATE aborts the request with no write.
        wait_ready("rst_mid");
        present(12, $urandom, 0, 0);
        @(negedge clk);
        train_valid = 1'b0;
        check("rst_mid_busy_fetch", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        seen = tbl_write_en;
        @(negedge clk);
        seen |= tbl_write_en;
        check("rst_mid_in_reset", {61'd0, train_ready, busy, tbl_write_en}, 64'b000);
        check("rst_mid_rd_addr", 64'(tbl_rd_addr), 64'd0);
        rst_n = 1'b1;
        exp_trained = 0;
        exp_skipped = 0;
        @(negedge clk);
        check("rst_mid_release", {62'd0, train_ready, busy}, 64'b10);
        repeat (6) begin
            @(negedge clk);
            seen |= tbl_write_en;
        end
        check("rst_mid_no_write", 64'(seen), 64'd0);

        // Randomized requests against the reference model.
        for (int r = 0; r < 40; r++) begin
            addr  = int'($urandom_range(0, 15));
            hist  = $urandom;
            taken = 1'($urandom_range(0, 1));
            y     = int'($urandom_range(0, 400)) - 200;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < NW; i++) begin
                    case ($urandom_range(0, 3))
                        0: mem[addr][i] = 8'sd127;
                        1: mem[addr][i] = -8'sd128;
                        2: mem[addr][i] = W'($urandom);
                        default: ;
                    endcase
                end
                ref_mem[addr] = mem[addr];
            end
            run_req($sformatf("rnd%0d", r), addr, hist, y, taken, model_need(y, taken),
                    1'b0, 0, 0, 0);
        end

`ifdef TRAIN_STATS_EN
        check("stat_trained", 64'(stat_trained), 64'(exp_trained));
        check("stat_skipped", 64'(stat_skipped), 64'(exp_skipped));
`endif
        $display("requests since last reset: trained=%0d skipped=%0d", exp_trained, exp_skipped);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
